video_timing_out: RTL and testbench



---
 rtl/video_timing_out.sv | 133 +++++++++++++
 tb/tb_video_timing_out.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_out.sv
// Raster timing generator and output alignment stage: drives hcount/vcount to the
// shader and registers its colour, with syncs and data enable delayed to match.
module video_timing_out #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit HSYNC_POL      = 1'b0,
  parameter bit VSYNC_POL      = 1'b0,
  parameter int SHADER_LATENCY = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        ce,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_too_big
      $error("video_timing_out: H_TOTAL/V_TOTAL must not exceed 4096");
    end
    if (SHADER_LATENCY < 0 || SHADER_LATENCY > 15) begin : g_latency_range
      $error("video_timing_out: SHADER_LATENCY must be within 0..15");
    end
  endgenerate

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  assign hcount = h_cnt;
  assign vcount = v_cnt;

  // Compare in 13 bits so a 4096-wide parameter never truncates to zero.
  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        de0;
  logic        hs0;
  logic        vs0;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};
  assign de0   = (h_ext < 13'(H_ACTIVE)) && (v_ext < 13'(V_ACTIVE));
  assign hs0   = (h_ext >= 13'(HS_START)) && (h_ext < 13'(HS_END));
  assign vs0   = (v_ext >= 13'(VS_START)) && (v_ext < 13'(VS_END));

  // Reset is folded in so no origin pulse is reported while held in reset.
  assign frame_start = ce && sys_rst_n && (h_cnt == 12'd0) && (v_cnt == 12'd0);

  // Tap k of each chain is the stage-0 decode delayed by k ce-cycles.
  logic [SHADER_LATENCY:0]   de_q;
  logic [SHADER_LATENCY:0]   hs_q;
  logic [SHADER_LATENCY:0]   vs_q;
  logic [SHADER_LATENCY+1:0] de_tap;
  logic [SHADER_LATENCY+1:0] hs_tap;
  logic [SHADER_LATENCY+1:0] vs_tap;

  assign de_tap = {de_q, de0};
  assign hs_tap = {hs_q, hs0};
  assign vs_tap = {vs_q, vs0};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
    end else if (ce) begin
      de_q <= de_tap[SHADER_LATENCY:0];
      hs_q <= hs_tap[SHADER_LATENCY:0];
      vs_q <= vs_tap[SHADER_LATENCY:0];
    end
  end

  // The shader's colour for a position arrives SHADER_LATENCY ce-cycles after it,
  // so it is gated with the enable from that same depth.
  logic de_gate;
  assign de_gate = de_tap[SHADER_LATENCY];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (ce) begin
      vga_r <= de_gate ? red_in   : 8'd0;
      vga_g <= de_gate ? green_in : 8'd0;
      vga_b <= de_gate ? blue_in  : 8'd0;
    end
  end

  assign vga_de    = de_q[SHADER_LATENCY];
  assign vga_hsync = hs_q[SHADER_LATENCY] ? HSYNC_POL : ~HSYNC_POL;
  assign vga_vsync = vs_q[SHADER_LATENCY] ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: tb/tb_video_timing_out.sv
// Scoreboard bench for video_timing_out on a shrunken raster with a pipelined shader model.
module tb_video_timing_out;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LAT = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        ce;
  logic [11:0] hcount, vcount;
  logic [7:0]  red_in, green_in, blue_in;
  logic        frame_start, vga_hsync, vga_vsync, vga_de;
  logic [7:0]  vga_r, vga_g, vga_b;

  always #5 sys_clk = ~sys_clk;

  video_timing_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SHADER_LATENCY(LAT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ce(ce),
    .hcount(hcount), .vcount(vcount),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .frame_start(frame_start), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } out_t;

  localparam out_t RST_OUT = '{de: 1'b0, hs: 1'b1, vs: 1'b1, r: 8'd0, g: 8'd0, b: 8'd0};

  out_t exp_q[$];
  out_t cur_exp;
  out_t shp[0:LAT];
  int   mh, mv;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
    end
  endtask

  function automatic logic pos_de(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  // Shader output: a position-dependent colour, deliberately 8'hFF in blanking.
  function automatic out_t shade(input int h, input int v);
    out_t c;
    c    = RST_OUT;
    c.r  = pos_de(h, v) ? 8'(h * 16 + v + 1) : 8'hFF;
    c.g  = pos_de(h, v) ? 8'(h + v * 3 + 2)  : 8'hFF;
    c.b  = pos_de(h, v) ? 8'(~h)             : 8'hFF;
    return c;
  endfunction

  function automatic out_t model_out(input int h, input int v);
    out_t o;
    out_t c;
    c    = shade(h, v);
    o.de = pos_de(h, v);
    o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    o.r  = o.de ? c.r : 8'd0;
    o.g  = o.de ? c.g : 8'd0;
    o.b  = o.de ? c.b : 8'd0;
    return o;
  endfunction

  task automatic check_outputs(input string phase);
    check({phase, ".hcount"}, hcount, mh);
    check({phase, ".vcount"}, vcount, mv);
    check({phase, ".vga_de"}, vga_de, cur_exp.de);
    check({phase, ".vga_hsync"}, vga_hsync, cur_exp.hs);
    check({phase, ".vga_vsync"}, vga_vsync, cur_exp.vs);
    check({phase, ".vga_r"}, vga_r, cur_exp.r);
    check({phase, ".vga_g"}, vga_g, cur_exp.g);
    check({phase, ".vga_b"}, vga_b, cur_exp.b);
  endtask

  task automatic model_reset();
    mh = 0;
    mv = 0;
    exp_q.delete();
    cur_exp = RST_OUT;
  endtask

  // One sys_clk cycle: check registered outputs, drive ce and shader colour,
  // then advance the model and retire the scoreboard entry that just came out.
  task automatic step(input string phase, input logic ce_v);
    @(negedge sys_clk);
    check_outputs(phase);
    ce       = ce_v;
    shp[0]   = shade(mh, mv);
    red_in   = shp[LAT].r;
    green_in = shp[LAT].g;
    blue_in  = shp[LAT].b;
    #1;
    check({phase, ".frame_start"}, frame_start, ce_v && sys_rst_n && mh == 0 && mv == 0);
    @(posedge sys_clk);
    #1;
    if (ce_v && sys_rst_n) begin
      exp_q.push_back(model_out(mh, mv));
      if (exp_q.size() == LAT + 1) cur_exp = exp_q.pop_front();
      for (int k = LAT; k > 0; k--) shp[k] = shp[k - 1];
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  endtask

  initial begin
    bit found;
    sys_rst_n = 1'b0;
    ce        = 1'b0;
    red_in    = 8'd0;
    green_in  = 8'd0;
    blue_in   = 8'd0;
    for (int k = 0; k <= LAT; k++) shp[k] = RST_OUT;
    model_reset();

    repeat (3) step("reset", 1'b1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step("ce_high", 1'b1);
    for (int i = 0; i < 600; i++) step("ce_1in4", (i % 4) == 0);
    for (int i = 0; i < 300; i++) step("ce_rand", 1'($urandom_range(0, 1)));

    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      if (mh == 5 && mv == 2) found = 1'b1;
      else step("seek", 1'b1);
    end
    check("seek_mid_frame", found, 1'b1);

    // Async reset asserted away from any clock edge.
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.frame_start", frame_start, 1'b0);
    repeat (3) step("rst_hold", 1'b1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step("restart", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
